// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing generator: pixel-rate divider, h/v counters, decoded
// video/sync outputs and per-pixel, per-line and per-frame strobes. Every output is a flop.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       video,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_en,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);

    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (CLK_DIV < 1)) begin : g_param_check
        $error("vga_sync_gen: totals must fit 10-bit counters and CLK_DIV must be >= 1");
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_count_q, h_count_d;
    logic [9:0]       v_count_q, v_count_d;
    logic             video_q, video_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             pix_en_q, pix_en_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             adv_s;

    // Pixel-rate divider and raster counters
    always_comb begin
        adv_s     = (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q + DIV_ONE;
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (adv_s) begin
            div_cnt_d = {DIV_W{1'b0}};
            if (h_count_q == H_LAST) begin
                h_count_d = 10'd0;
                v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
            end else begin
                h_count_d = h_count_q + 10'd1;
            end
        end else begin
            h_count_d = h_count_q;
            v_count_d = v_count_q;
        end
    end

    // Decode from the next counter values so the registered flags line up with the counters;
    // holding between advances keeps video low after reset until the first real pixel step.
    always_comb begin
        video_d = video_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (adv_s) begin
            video_d = (h_count_d < H_VIS) && (v_count_d < V_VIS);
            hsync_d = ((h_count_d >= HS_BEG) && (h_count_d < HS_END)) ? SYNC_ON : ~SYNC_ON;
            vsync_d = ((v_count_d >= VS_BEG) && (v_count_d < VS_END)) ? SYNC_ON : ~SYNC_ON;
        end else begin
            video_d = video_q;
            hsync_d = hsync_q;
            vsync_d = vsync_q;
        end
        pix_en_d      = adv_s;
        line_start_d  = adv_s && (h_count_d == 10'd0);
        frame_start_d = line_start_d && (v_count_d == 10'd0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= {DIV_W{1'b0}};
            h_count_q     <= 10'd0;
            v_count_q     <= 10'd0;
            video_q       <= 1'b0;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            video_q       <= video_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_en_q      <= pix_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_count     = h_count_q;
    assign v_count     = v_count_q;
    assign video       = video_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pix_en      = pix_en_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
